switch_input_ctrl: RTL and testbench

//  Avalon-MM slave controller for the board slide switches on the Nios/HPS system.
//  - Synchronises in_port and debounces each bit.
//  - Captures both edges per bit into a sticky register; masked edges raise irq.
//  - Nios reads the debounced switch state and services the edge interrupt.

---
 rtl/switch_ctrl_pkg.sv | 9 +
 rtl/switch_debounce.sv | 47 ++++
 rtl/switch_input_ctrl.sv | 57 +++++
 tb/tb_switch_input_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/switch_ctrl_pkg.sv
// switch_ctrl_pkg: register addresses and counter sizing for switch_input_ctrl.
package switch_ctrl_pkg;
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;
    function automatic int cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction
endpackage

// File: rtl/switch_debounce.sv
// switch_debounce: one switch bit, 2-FF synchroniser plus debounce filter.
// SWITCH_DEBOUNCE_EN selects the counter filter; otherwise stable follows sync.
module switch_debounce
    import switch_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din_i,
    output logic stable_o,
    output logic change_o
);
    logic meta_q, sync_q, stable_q, stable_d;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            meta_q   <= din_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
        end
    end
`ifdef SWITCH_DEBOUNCE_EN
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic expired;
    // Any agreement with the stable value restarts the count.
    always_comb begin
        expired  = (sync_q != stable_q) && (cnt_q == CNT_MAX);
        stable_d = expired ? sync_q : stable_q;
        cnt_d    = (sync_q == stable_q || expired) ? '0 : cnt_q + CW'(1);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    localparam int unused_cycles = DEBOUNCE_CYCLES;
    assign stable_d = sync_q;
`endif
    assign stable_o = stable_q;
    assign change_o = stable_d ^ stable_q;
endmodule

// File: rtl/switch_input_ctrl.sv
// switch_input_ctrl: Avalon-MM slave for slide switches with edge capture and irq.
// Build macro SWITCH_DEBOUNCE_EN enables the per-bit debounce counters.
module switch_input_ctrl
    import switch_ctrl_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    logic [WIDTH-1:0] stable, change, mask_q, mask_d, edgecap_q, edgecap_d, w1c;
    logic [31:0] readdata_q, readdata_d, unused_wd;
    logic irq_q, wr;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .din_i   (in_port[i]),
            .stable_o(stable[i]),
            .change_o(change[i])
        );
    end
    assign unused_wd = writedata;
    // A new edge overrides a simultaneous W1C on the same bit.
    always_comb begin
        wr         = chipselect & write;
        mask_d     = (wr && address == ADDR_IRQMASK) ? writedata[WIDTH-1:0] : mask_q;
        w1c        = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
        edgecap_d  = (edgecap_q & ~w1c) | change;
        readdata_d = (address == ADDR_DATA)    ? 32'(stable)    :
                     (address == ADDR_IRQMASK) ? 32'(mask_q)    :
                     (address == ADDR_EDGECAP) ? 32'(edgecap_q) : '0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q     <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= |(edgecap_q & mask_q);
        end
    end
    assign readdata = readdata_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_switch_input_ctrl.sv
// tb_switch_input_ctrl: scoreboard bench with a cycle-level reference model of
// the switch controller; works with SWITCH_DEBOUNCE_EN defined or undefined.
module tb_switch_input_ctrl;
    localparam int W  = 10;
    localparam int DC = 4;
`ifdef SWITCH_DEBOUNCE_EN
    localparam int DCM = DC;
`else
    localparam int DCM = 1;
`endif
    localparam int LAT = 2 + DCM + 1;

    logic        clk = 0, reset_n, chipselect, write, irq;
    logic [1:0]  address;
    logic [31:0] writedata, readdata;
    logic [W-1:0] in_port;
    bit rd_req, mon_vld, ok;
    int n_total = 0, n_pass = 0;

    logic [W-1:0] m_s1, m_s2, m_stable, m_edge, m_mask, ns, w1c;
    logic [W-1:0] hist[$];
    logic [31:0]  exp_rd_q[$], exp_rd;
    logic         exp_irq_q[$], exp_irq;

    switch_input_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write(write), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a bit becomes stable once the last DCM synchronised
    // samples all disagree with its current stable value.
    always @(posedge clk) begin
        if (!reset_n) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_edge = '0; m_mask = '0;
            hist.delete();
            mon_vld = 0;
        end else begin
            exp_rd  = (address == 2'd0) ? {22'b0, m_stable} :
                      (address == 2'd2) ? {22'b0, m_mask}   :
                      (address == 2'd3) ? {22'b0, m_edge}   : 32'b0;
            exp_irq = |(m_edge & m_mask);
            hist.push_back(m_s2);
            if (hist.size() > DCM) void'(hist.pop_front());
            ns = m_stable;
            for (int b = 0; b < W; b++) begin
                ok = (hist.size() == DCM);
                foreach (hist[j]) if (hist[j][b] == m_stable[b]) ok = 0;
                if (ok) ns[b] = ~m_stable[b];
            end
            w1c = (chipselect && write && address == 2'd3) ? writedata[W-1:0] : '0;
            m_edge = (m_edge & ~w1c) | (ns ^ m_stable);
            if (chipselect && write && address == 2'd2) m_mask = writedata[W-1:0];
            m_stable = ns;
            m_s2 = m_s1;
            m_s1 = in_port;
            mon_vld = rd_req;
            if (rd_req) begin
                exp_rd_q.push_back(exp_rd);
                exp_irq_q.push_back(exp_irq);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_vld) begin
            if (exp_rd_q.size() == 0) begin
                chk("sb_underflow", 32'(exp_rd_q.size()), 32'd1);
            end else begin
                chk("sb_readdata", readdata, exp_rd_q.pop_front());
                chk("sb_irq", 32'(irq), 32'(exp_irq_q.pop_front()));
            end
        end
    end

    initial begin
        reset_n = 0; in_port = '0; address = 0; chipselect = 0; write = 0;
        writedata = '0; rd_req = 0;
        repeat (3) tick();
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        reset_n = 1; rd_req = 1;
        foreach (exp_rd[k]) if (k < 3) begin
            address = (k == 0) ? 2'd0 : (k == 1) ? 2'd2 : 2'd3;
            tick();
            chk("reset_reg_read", readdata, 32'h0);
        end
`ifndef SWITCH_DEBOUNCE_EN
        address = 2'd0; in_port = 10'h155;
        repeat (4) tick();
        chk("nodb_data", readdata, 32'h155);
        in_port = 10'h154; tick(); in_port = 10'h155;
        repeat (3) tick();
        chk("nodb_glitch", readdata, 32'h154);
        tick();
        chk("nodb_restore", readdata, 32'h155);
        in_port = '0;
        repeat (4) tick();
`endif
        // Short pulse on bit 0, then let it settle.
        in_port = 10'h001; tick(); tick(); in_port = '0;
        for (int i = 0; i < 10; i++) begin
            address = i[0] ? 2'd3 : 2'd0;
            tick();
        end
`ifdef SWITCH_DEBOUNCE_EN
        address = 2'd0; tick();
        chk("pulse_data", readdata, 32'h0);
        address = 2'd3; tick();
        chk("pulse_edgecap", readdata, 32'h0);
`endif
        address = 2'd3; writedata = 32'hFFFF_FFFF; chipselect = 1; write = 1;
        tick(); chipselect = 0; write = 0;
        address = 2'd0; in_port = 10'h3FF;
        for (int i = 1; i <= LAT; i++) begin
            tick();
            if (i == LAT - 1) chk("lat_before", readdata, 32'h0);
            if (i == LAT)     chk("lat_exact", readdata, 32'h3FF);
        end
        address = 2'd3; tick();
        chk("edgecap_all", readdata, 32'h3FF);
        chk("irq_masked", 32'(irq), 32'h0);
        address = 2'd2; writedata = 32'h1; chipselect = 1; write = 1;
        tick(); chipselect = 0; write = 0;
        chk("irq_pre", 32'(irq), 32'h0);
        tick();
        chk("irq_set", 32'(irq), 32'h1);
        address = 2'd3; writedata = 32'h1; chipselect = 1; write = 1;
        tick(); chipselect = 0; write = 0;
        chk("irq_hold", 32'(irq), 32'h1);
        tick();
        chk("irq_clear", 32'(irq), 32'h0);
        chk("w1c_bit0", 32'(readdata[0]), 32'h0);
        // W1C collides with the stable[0] fall.
        in_port = 10'h3FE;
        repeat (LAT - 2) tick();
        writedata = 32'h1; chipselect = 1; write = 1;
        tick(); chipselect = 0; write = 0;
        tick();
        chk("collide_bit0", 32'(readdata[0]), 32'h1);
        chk("collide_irq", 32'(irq), 32'h1);
        // Reset in the middle of a transition.
        in_port = 10'h2AA;
        repeat (3) tick();
        rd_req = 0; tick();
        reset_n = 0; tick(); tick();
        chk("midreset_rd", readdata, 32'h0);
        reset_n = 1; rd_req = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5) == 0) in_port = W'($urandom);
            address    = 2'($urandom);
            chipselect = ($urandom_range(3) == 0);
            write      = $urandom_range(1);
            writedata  = $urandom;
            tick();
        end
        chipselect = 0; write = 0; rd_req = 0;
        repeat (3) tick();
        chk("sb_drained", 32'(exp_rd_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
